// File: rtl/mrd_ctrl_pkg.sv
// Shared types and constants for the mixed-radix DFT stage frame controller.
// Holds the frame state encoding and the legal frame-length check.
package mrd_ctrl_pkg;

    localparam int MRD_MAX_PTS = 1200;
    localparam int MRD_ADDR_W  = 11;
    localparam int MRD_PTS_W   = 12;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SINK    = 3'd1,
        ST_DISCARD = 3'd2,
        ST_CALC    = 3'd3,
        ST_SOURCE  = 3'd4
    } mrd_frm_state_e;

    function automatic logic mrd_len_legal(input logic [MRD_PTS_W-1:0] pts,
                                           input int max_pts);
        return (pts != 12'd0) && (pts <= MRD_PTS_W'(max_pts));
    endfunction

endpackage

// File: rtl/mrd_delay_line.sv
// Fixed-depth shift register with synchronous clear; carries the compute
// read strobe and address forward to line up with the butterfly write-back.
module mrd_delay_line #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    // Next-stage values: shift by one, or flush every stage on clear.
    always_comb begin
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = {WIDTH{1'b0}};
            end
        end else begin
            stage_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_d[i] = stage_q[i-1];
            end
        end
    end

    // Stage registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/mrd_frame_ctrl.sv
// Frame sequencer for one mixed-radix DFT stage: sinks a frame into the stage
// RAM, sweeps it through the butterfly pipeline, then streams it out.
module mrd_frame_ctrl
    import mrd_ctrl_pkg::*;
#(
    parameter int MAX_PTS  = MRD_MAX_PTS,
    parameter int CALC_LAT = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic                  in_sop,
    input  logic                  in_eop,
    input  logic [MRD_PTS_W-1:0]  in_dftpts,
    input  logic                  in_inverse,
    output logic                  in_ready,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic                  out_sop,
    output logic                  out_eop,
    output logic                  ram_wr_en,
    output logic [MRD_ADDR_W-1:0] ram_wr_addr,
    output logic                  ram_rd_en,
    output logic [MRD_ADDR_W-1:0] ram_rd_addr,
    output logic [MRD_PTS_W-1:0]  cfg_dftpts,
    output logic                  cfg_inverse,
    output logic                  is_sink_stat,
    output logic                  is_rd_stat,
    output logic                  is_wr_stat,
    output logic                  is_source_stat,
    output logic                  err_len,
    output logic                  err_cfg
);

    localparam logic [MRD_ADDR_W-1:0] LAT_A = MRD_ADDR_W'(CALC_LAT);
    localparam int DL_W = MRD_ADDR_W + 1;

    mrd_frm_state_e        state_q, state_d;
    logic [MRD_ADDR_W-1:0] cnt_q, cnt_d;
    logic [MRD_PTS_W-1:0]  cfg_dftpts_q, cfg_dftpts_d;
    logic                  cfg_inverse_q, cfg_inverse_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_sop_q, out_sop_d;
    logic                  out_eop_q, out_eop_d;
    logic                  err_len_q, err_len_d;
    logic                  err_cfg_q, err_cfg_d;

    logic [MRD_ADDR_W-1:0] n_m1_s;
    logic [MRD_ADDR_W-1:0] calc_last_s;
    logic                  accept_s;
    logic                  legal_s;
    logic                  calc_rd_s;
    logic                  src_rd_s;
    logic                  dl_clr_s;
    logic [DL_W-1:0]       dl_din_s;
    logic [DL_W-1:0]       dl_dout_s;

    assign n_m1_s      = cfg_dftpts_q[MRD_ADDR_W-1:0] - 11'd1;
    assign calc_last_s = n_m1_s + LAT_A;
    assign legal_s     = mrd_len_legal(in_dftpts, MAX_PTS);

    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_SINK) || (state_q == ST_DISCARD);
    assign accept_s = in_valid && in_ready;

    // One shared counter: sink address, compute sweep, then source address.
    assign calc_rd_s = (state_q == ST_CALC) && (cnt_q <= n_m1_s);
    assign src_rd_s  = (state_q == ST_SOURCE) && out_ready && (cnt_q <= n_m1_s);

    assign dl_clr_s = (state_d == ST_CALC) && (state_q != ST_CALC);
    assign dl_din_s = {calc_rd_s, (calc_rd_s ? cnt_q : 11'd0)};

    mrd_delay_line #(
        .DEPTH (CALC_LAT),
        .WIDTH (DL_W)
    ) u_wb_delay (
        .clk  (clk),
        .rst  (rst),
        .clr  (dl_clr_s),
        .din  (dl_din_s),
        .dout (dl_dout_s)
    );

    // RAM port steering: sink writes, delayed write-back, compute and source reads.
    always_comb begin
        ram_wr_en   = 1'b0;
        ram_wr_addr = 11'd0;
        if ((state_q == ST_IDLE) && accept_s && in_sop && legal_s) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = 11'd0;
        end else if ((state_q == ST_SINK) && accept_s) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = cnt_q;
        end else if ((state_q == ST_CALC) && dl_dout_s[DL_W-1]) begin
            ram_wr_en   = 1'b1;
            ram_wr_addr = dl_dout_s[MRD_ADDR_W-1:0];
        end else begin
            ram_wr_en   = 1'b0;
            ram_wr_addr = 11'd0;
        end
        ram_rd_en   = calc_rd_s || src_rd_s;
        ram_rd_addr = (calc_rd_s || src_rd_s) ? cnt_q : 11'd0;
    end

    assign is_sink_stat   = (state_q == ST_SINK);
    assign is_rd_stat     = calc_rd_s;
    assign is_wr_stat     = (state_q == ST_CALC) && dl_dout_s[DL_W-1];
    assign is_source_stat = (state_q == ST_SOURCE);

    // Next-state, counter, configuration and registered-output logic.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cfg_dftpts_d  = cfg_dftpts_q;
        cfg_inverse_d = cfg_inverse_q;
        err_len_d     = 1'b0;
        err_cfg_d     = 1'b0;
        out_valid_d   = src_rd_s;
        out_sop_d     = src_rd_s && (cnt_q == 11'd0);
        out_eop_d     = src_rd_s && (cnt_q == n_m1_s);
        case (state_q)
            ST_IDLE: begin
                if (accept_s && in_sop) begin
                    if (legal_s) begin
                        cfg_dftpts_d  = in_dftpts;
                        cfg_inverse_d = in_inverse;
                        // The SOP beat is beat 0 and obeys the same end-of-frame rules.
                        if (in_dftpts == 12'd1) begin
                            state_d   = ST_CALC;
                            cnt_d     = 11'd0;
                            err_len_d = !in_eop;
                        end else if (in_eop) begin
                            state_d   = ST_IDLE;
                            cnt_d     = 11'd0;
                            err_len_d = 1'b1;
                        end else begin
                            state_d = ST_SINK;
                            cnt_d   = 11'd1;
                        end
                    end else begin
                        err_cfg_d = 1'b1;
                        state_d   = in_eop ? ST_IDLE : ST_DISCARD;
                        cnt_d     = 11'd0;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SINK: begin
                if (accept_s) begin
                    if (cnt_q == n_m1_s) begin
                        state_d   = ST_CALC;
                        cnt_d     = 11'd0;
                        err_len_d = !in_eop;
                    end else if (in_eop) begin
                        state_d   = ST_IDLE;
                        cnt_d     = 11'd0;
                        err_len_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 11'd1;
                    end
                end else begin
                    state_d = ST_SINK;
                end
            end
            ST_DISCARD: begin
                if (accept_s && in_eop) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DISCARD;
                end
            end
            ST_CALC: begin
                if (cnt_q == calc_last_s) begin
                    state_d = ST_SOURCE;
                    cnt_d   = 11'd0;
                end else begin
                    cnt_d = cnt_q + 11'd1;
                end
            end
            ST_SOURCE: begin
                if (out_eop_q) begin
                    state_d = ST_IDLE;
                    cnt_d   = 11'd0;
                end else if (src_rd_s) begin
                    cnt_d = cnt_q + 11'd1;
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 11'd0;
            end
        endcase
    end

    // State, counter, configuration and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 11'd0;
            cfg_dftpts_q  <= 12'd0;
            cfg_inverse_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_sop_q     <= 1'b0;
            out_eop_q     <= 1'b0;
            err_len_q     <= 1'b0;
            err_cfg_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cfg_dftpts_q  <= cfg_dftpts_d;
            cfg_inverse_q <= cfg_inverse_d;
            out_valid_q   <= out_valid_d;
            out_sop_q     <= out_sop_d;
            out_eop_q     <= out_eop_d;
            err_len_q     <= err_len_d;
            err_cfg_q     <= err_cfg_d;
        end
    end

    assign cfg_dftpts  = cfg_dftpts_q;
    assign cfg_inverse = cfg_inverse_q;
    assign out_valid   = out_valid_q;
    assign out_sop     = out_sop_q;
    assign out_eop     = out_eop_q;
    assign err_len     = err_len_q;
    assign err_cfg     = err_cfg_q;

endmodule

// File: doc/mrd_frame_ctrl.md
# mrd_frame_ctrl

Frame-level sequencer for one mixed-radix DFT stage. Accepts a frame on the streaming sink, steps it through write, compute (radix-2/3/4/5 read/write-back) and source phases, and produces RAM addresses, enables and the four phase-status flags consumed by the stage datapath. It latches per-frame configuration (`dftpts`, `inverse`) at start-of-packet. It sits between the upstream `mrd_st_if` producer, the stage buffer RAM and the `mrd_rdx2345` butterfly pipeline.

## Interface
- `MAX_PTS`, 1200: largest legal `dftpts`.
- `CALC_LAT`, 8: cycles from compute read-enable to matching write-back enable (butterfly pipeline latency plus RAM read latency); ≥1.
- `clk`  in  1  single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `in_valid`, `in_sop`, `in_eop`  in  1 each  sink handshake/framing.
- `in_dftpts`  in  12  DFT length; sampled only on the accepted SOP beat.
- `in_inverse`  in  1  IDFT flag; sampled with `in_dftpts`.
- `in_ready`  out  1  sink ready.
- `out_ready`  in  1  downstream ready.
- `out_valid`, `out_sop`, `out_eop`  out  1 each  source framing, aligned with the RAM read data.
- `ram_wr_en`  out  1  RAM write (sink or write-back).
- `ram_wr_addr`  out  11  RAM write address.
- `ram_rd_en`  out  1  RAM read (compute or source).
- `ram_rd_addr`  out  11  RAM read address.
- `cfg_dftpts`  out  12  latched frame length.
- `cfg_inverse`  out  1  latched IDFT flag.
- `is_sink_stat`, `is_rd_stat`, `is_wr_stat`, `is_source_stat`  out  1 each  phase flags.
- `err_len`  out  1  one-cycle pulse: EOP/length mismatch.
- `err_cfg`  out  1  one-cycle pulse: illegal `dftpts`.

## Operation
- States: IDLE, SINK, DISCARD, CALC, SOURCE.
- IDLE:
  - `in_ready`=1.
  - Beats without SOP are accepted and dropped.
  - Accepted SOP with `1 ≤ dftpts ≤ MAX_PTS`: latch N = `dftpts` and `inverse`, write that beat at addr 0, go to SINK. If the beat also has EOP and N=1, go directly to CALC.
  - Otherwise: pulse `err_cfg` and go to DISCARD, or stay in IDLE if that beat has EOP.
- SINK:
  - `in_ready`=1; `is_sink_stat`=1.
  - Each accepted beat is written at sequential addresses 1..N-1.
  - Beat N-1 with EOP → CALC.
  - Beat N-1 without EOP → `err_len` pulse, CALC. The rest of the extra input up to EOP is accepted and dropped in IDLE.
  - EOP before beat N-1 → `err_len` pulse, IDLE; the frame is abandoned.
  - SOP mid-frame is ignored (treated as data).
- DISCARD: `in_ready`=1, no writes; accepted EOP → IDLE.
- CALC:
  - `in_ready`=0; `is_rd_stat`=1 while read addresses are issued.
  - `ram_rd_en`=1 for N consecutive cycles, `ram_rd_addr` 0..N-1.
  - `ram_wr_en`/`ram_wr_addr` equal `ram_rd_en`/`ram_rd_addr` delayed by exactly CALC_LAT cycles; `is_wr_stat`=1 while a delayed enable is in flight.
  - Exit to SOURCE the cycle after the last write-back: CALC lasts N+CALC_LAT cycles.
- SOURCE:
  - `in_ready`=0; `is_source_stat`=1.
  - Issue `ram_rd_en` at addresses 0..N-1, one per cycle, only when `out_ready`=1.
  - `out_valid` = `ram_rd_en` delayed one cycle. `out_sop` marks addr 0 and `out_eop` marks addr N-1, delayed the same way.
  - Downstream must absorb one in-flight beat after dropping `out_ready`.
  - → IDLE the cycle after the EOP beat is presented.
- Arithmetic: counters are 11 bits. Every address compares against N-1 with no wrap. The CALC delay line is cleared on entry to CALC.
- Reset (any state, mid-frame): state IDLE, all counters and delay lines 0, every output 0 except `in_ready`=1. `cfg_*` become 0.

## Timing
- `in_ready`, `ram_*`, status flags: combinational from registered state/counters plus current sink handshake. `out_*` and `err_*` are registered.
- Sink write occurs in the same cycle as the accepted beat.
- Sink-EOP to first compute read: 1 cycle.
- Frame latency from last sink beat to `out_sop`, with `out_ready` held high: 1 + N + CALC_LAT + 1 cycles.
- Minimum gap between frames: the next SOP is accepted the cycle after the source EOP.

## Structure
- `mrd_ctrl_pkg` holds:
  - the state enum `mrd_frm_state_e`;
  - `MRD_MAX_PTS` and `MRD_ADDR_W` (11);
  - the legal-length check function.
- One sub-module, `mrd_delay_line` (parameter `DEPTH`, `WIDTH`, synchronous clear), carries the {wr_en, addr} CALC_LAT delay. The top-level FSM and counters form a single module.

## Test plan
- N=12, CALC_LAT=8, contiguous sink with EOP on beat 11:
  - 12 writes at addr 0..11;
  - 12 reads, then 12 write-backs starting exactly 8 cycles after the first read;
  - `out_sop` 22 cycles after the sink EOP cycle, `out_eop` 11 cycles later;
  - `cfg_dftpts`=12.
- N=60 with `out_ready` toggled 1/0 every 3 cycles: exactly 60 `out_valid` beats, addresses monotonic, no skipped or duplicated addr.
- Sink `dftpts`=1201:
  - `err_cfg` pulse;
  - no `ram_wr_en`;
  - beats consumed through EOP;
  - a following N=4 frame processes normally.
- N=24 with EOP on beat 9: `err_len` pulse, return to IDLE, no CALC reads issued.
- N=1 single beat carrying SOP+EOP: 1 write, 1 read, 1 write-back, and one output beat with `out_sop`=`out_eop`=1.
- `rst` asserted mid-CALC on frame N=36:
  - next cycle IDLE, all enables 0, `in_ready`=1;
  - a new N=12 frame then completes per scenario 1 timing.
